shot_pool_move: RTL and testbench

Multi-projectile motion engine for the player's shots: a pool of `NUM_SHOTS` independent slots, each launched from the player position in one of eight directions and advanced once per frame in fixed point. Slots retire on per-slot collision or on leaving the playfield box. It sits between the player controller (trigger, direction, position) and the shot drawing/collision logic, which consume the per-slot coordinates and active flags.

---
 rtl/shot_pool_move.sv | 144 ++++++++++++++
 tb/tb_shot_pool_move.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shot_pool_move.sv
// Player shot pool: lowest free slot launches on trigger edge, moves per frame, retires on hit/out-of-box.
// Registered outputs one cycle after launch/frame; no backpressure (edges without canFire drop); SHOT_DIAGONAL_EN adds diagonals.
module shot_pool_move #(
   parameter int NUM_SHOTS       = 4,
   parameter int SPEED           = 100,
   parameter int FRAC_BITS       = 6,
   parameter int X_MIN           = 0,
   parameter int X_MAX           = 639,
   parameter int Y_MIN           = 2,
   parameter int Y_MAX           = 479,
   parameter int PARK_XY         = 781,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          startOfFrame,
   input  logic                          pause,
   input  logic                          triggerShot,
   input  logic [2:0]                    shotDirection,
   input  logic signed [10:0]            player_topLeftX,
   input  logic signed [10:0]            player_topLeftY,
   input  logic [NUM_SHOTS-1:0]          collision,
   output logic [NUM_SHOTS-1:0]          shotActive,
   output logic signed [NUM_SHOTS*11-1:0] shotsX,
   output logic signed [NUM_SHOTS*11-1:0] shotsY,
   output logic                          canFire
);

   localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
   localparam logic signed [31:0] PARK_FP = 32'(PARK_XY * (2 ** FRAC_BITS));
   localparam logic signed [31:0] SPD     = 32'(SPEED);
`ifdef SHOT_DIAGONAL_EN
   localparam logic signed [31:0] DIAG    = 32'((SPEED * 45) >> 6);
`endif

   logic signed [31:0] pos_x [NUM_SHOTS];
   logic signed [31:0] pos_y [NUM_SHOTS];
   logic signed [31:0] vel_x [NUM_SHOTS];
   logic signed [31:0] vel_y [NUM_SHOTS];
   logic signed [31:0] nxt_x [NUM_SHOTS];
   logic signed [31:0] nxt_y [NUM_SHOTS];
   logic [NUM_SHOTS-1:0] active;
   logic [NUM_SHOTS-1:0] oob;
   logic [NUM_SHOTS-1:0] launch_sel;
   logic                 sel_found;
   logic [CW-1:0]        cooldown;
   logic                 trig_prev;
   logic                 launch;
   logic                 frame_tick;
   logic signed [31:0]   launch_vx;
   logic signed [31:0]   launch_vy;
   logic signed [31:0]   launch_px;
   logic signed [31:0]   launch_py;

   assign canFire    = (|(~active)) && (cooldown == '0) && !pause;
   assign launch     = triggerShot && !trig_prev && canFire;
   assign frame_tick = startOfFrame && !pause;
   assign launch_px  = {{21{player_topLeftX[10]}}, player_topLeftX} <<< FRAC_BITS;
   assign launch_py  = {{21{player_topLeftY[10]}}, player_topLeftY} <<< FRAC_BITS;

   always_comb begin
      launch_vx = '0;
      launch_vy = -SPD;
      case (shotDirection)
         3'd2: begin launch_vx = SPD;   launch_vy = '0;    end
         3'd4: begin launch_vx = '0;    launch_vy = SPD;   end
         3'd6: begin launch_vx = -SPD;  launch_vy = '0;    end
`ifdef SHOT_DIAGONAL_EN
         3'd1: begin launch_vx = DIAG;  launch_vy = -DIAG; end
         3'd3: begin launch_vx = DIAG;  launch_vy = DIAG;  end
         3'd5: begin launch_vx = -DIAG; launch_vy = DIAG;  end
         3'd7: begin launch_vx = -DIAG; launch_vy = -DIAG; end
`endif
         default: ;
      endcase
   end

   // Bounds are tested on the moved pixel so a slot never reports an off-box coordinate.
   always_comb begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
         nxt_x[i] = pos_x[i] + vel_x[i];
         nxt_y[i] = pos_y[i] + vel_y[i];
         oob[i]   = ((nxt_x[i] >>> FRAC_BITS) < X_MIN) || ((nxt_x[i] >>> FRAC_BITS) > X_MAX) ||
                    ((nxt_y[i] >>> FRAC_BITS) < Y_MIN) || ((nxt_y[i] >>> FRAC_BITS) > Y_MAX);
      end
   end

   always_comb begin
      launch_sel = '0;
      sel_found  = 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         if (!active[i] && !sel_found) begin
            launch_sel[i] = launch;
            sel_found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         trig_prev <= 1'b0;
         cooldown  <= '0;
         active    <= '0;
         for (int i = 0; i < NUM_SHOTS; i++) begin
            pos_x[i] <= PARK_FP;
            pos_y[i] <= PARK_FP;
            vel_x[i] <= '0;
            vel_y[i] <= '0;
         end
      end else begin
         trig_prev <= triggerShot;
         if (launch)
            cooldown <= CW'(COOLDOWN_FRAMES);
         else if (frame_tick && cooldown != '0)
            cooldown <= cooldown - 1'b1;
         for (int i = 0; i < NUM_SHOTS; i++) begin
            if ((active[i] && collision[i]) || (active[i] && frame_tick && oob[i])) begin
               active[i] <= 1'b0;
               pos_x[i]  <= PARK_FP;
               pos_y[i]  <= PARK_FP;
               vel_x[i]  <= '0;
               vel_y[i]  <= '0;
            end else if (launch_sel[i]) begin
               active[i] <= 1'b1;
               pos_x[i]  <= launch_px;
               pos_y[i]  <= launch_py;
               vel_x[i]  <= launch_vx;
               vel_y[i]  <= launch_vy;
            end else if (active[i] && frame_tick) begin
               pos_x[i] <= nxt_x[i];
               pos_y[i] <= nxt_y[i];
            end
         end
      end
   end

   assign shotActive = active;

   for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_out
      assign shotsX[11*g +: 11] = pos_x[g][FRAC_BITS+10:FRAC_BITS];
      assign shotsY[11*g +: 11] = pos_y[g][FRAC_BITS+10:FRAC_BITS];
   end

endmodule

// File: tb/tb_shot_pool_move.sv
// Directed bench for shot_pool_move: vector table for single-shot motion, then multi-cycle sequences.
module tb_shot_pool_move;

   logic              clk = 1'b0;
   logic              resetN = 1'b0;
   logic              startOfFrame = 1'b0;
   logic              pause = 1'b0;
   logic              triggerShot = 1'b0;
   logic [2:0]        shotDirection = 3'd0;
   logic signed [10:0] player_topLeftX = 11'sd320;
   logic signed [10:0] player_topLeftY = 11'sd400;
   logic [3:0]        collision = 4'b0;
   logic [3:0]        shotActive;
   logic signed [43:0] shotsX;
   logic signed [43:0] shotsY;
   logic              canFire;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shot_pool_move dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
      .triggerShot(triggerShot), .shotDirection(shotDirection),
      .player_topLeftX(player_topLeftX), .player_topLeftY(player_topLeftY),
      .collision(collision), .shotActive(shotActive), .shotsX(shotsX),
      .shotsY(shotsY), .canFire(canFire)
   );

   typedef struct {
      logic       trig;
      logic       sof;
      logic       pau;
      logic [3:0] col;
      int         e_act;
      int         e_x0;
      int         e_y0;
      int         e_cf;
   } rec_t;

   rec_t tbl [8];

   function automatic int sx(input int i);
      logic signed [10:0] v;
      v = shotsX[11*i +: 11];
      return int'(v);
   endfunction

   function automatic int sy(input int i);
      logic signed [10:0] v;
      v = shotsY[11*i +: 11];
      return int'(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic t, input logic s, input logic p, input logic [3:0] c);
      @(negedge clk);
      triggerShot  = t;
      startOfFrame = s;
      pause        = p;
      collision    = c;
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n, input logic t);
      repeat (n) step(t, 1'b1, 1'b0, 4'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0;
      triggerShot = 1'b0; startOfFrame = 1'b0; pause = 1'b0; collision = 4'b0;
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1, 320, 400, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1, 320, 398, 0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1, 320, 398, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1, 320, 396, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1, 320, 395, 0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 4'b0000, 1, 320, 395, 0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b0001, 0, 781, 781, 0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 4'b0001, 0, 781, 781, 0};

      do_reset();
      #1;
      check("reset_active", int'(shotActive), 0);
      check("reset_x3", sx(3), 781);
      check("reset_y0", sy(0), 781);
      check("reset_canfire", int'(canFire), 1);

      player_topLeftX = 11'sd320; player_topLeftY = 11'sd400; shotDirection = 3'd0;
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].trig, tbl[i].sof, tbl[i].pau, tbl[i].col);
         check($sformatf("vec%0d_active", i), int'(shotActive), tbl[i].e_act);
         check($sformatf("vec%0d_x0", i), sx(0), tbl[i].e_x0);
         check($sformatf("vec%0d_y0", i), sy(0), tbl[i].e_y0);
         check($sformatf("vec%0d_canfire", i), int'(canFire), tbl[i].e_cf);
      end
      frames(3, 1'b0);
      check("vec_cooldown_7", int'(canFire), 0);
      frames(1, 1'b0);
      check("vec_cooldown_8", int'(canFire), 1);

      // Fill the pool, drop a fifth edge, free slot 2 by collision and refill it.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0, 4'b0);
         check($sformatf("fill_slot%0d", k), int'(shotActive[k]), 1);
         frames(9, 1'b0);
      end
      check("full_active", int'(shotActive), 15);
      check("full_canfire", int'(canFire), 0);
      step(1'b1, 1'b0, 1'b0, 4'b0);
      check("fifth_dropped", int'(shotActive), 15);
      step(1'b0, 1'b0, 1'b0, 4'b0100);
      check("col2_active", int'(shotActive), 11);
      check("col2_x", sx(2), 781);
      check("col2_y", sy(2), 781);
      check("col2_canfire", int'(canFire), 1);
      step(1'b1, 1'b0, 1'b0, 4'b0);
      check("refill_active", int'(shotActive), 15);
      check("refill_x2", sx(2), 320);
      check("refill_y2", sy(2), 400);
      frames(8, 1'b0);
      check("slot0_y_44f", sy(0), 331);
      step(1'b1, 1'b0, 1'b0, 4'b0001);
      check("col_launch_same", int'(shotActive), 14);
      step(1'b0, 1'b0, 1'b0, 4'b0);
      step(1'b1, 1'b1, 1'b0, 4'b0);
      check("launch_sof_active", int'(shotActive), 15);
      check("launch_sof_y0", sy(0), 400);
      check("launch_sof_y1", sy(1), 343);
      step(1'b0, 1'b0, 1'b0, 4'b1110);
      check("multi_col", int'(shotActive), 1);
      frames(7, 1'b0);
      check("load_wins_7", int'(canFire), 0);
      frames(1, 1'b0);
      check("load_wins_8", int'(canFire), 1);

      // Cooldown drop and trigger held high.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 4'b0);
      frames(3, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'b0);
      check("cool_drop", int'(shotActive), 1);
      step(1'b0, 1'b0, 1'b0, 4'b0);
      frames(4, 1'b0);
      check("cool_7f", int'(canFire), 0);
      frames(1, 1'b0);
      check("cool_8f", int'(canFire), 1);
      step(1'b1, 1'b0, 1'b0, 4'b0);
      check("held_first", int'(shotActive), 3);
      frames(9, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'b0);
      check("held_once", int'(shotActive), 3);
      check("held_canfire", int'(canFire), 1);

      // Right edge retirement.
      do_reset();
      player_topLeftX = 11'sd630; player_topLeftY = 11'sd200; shotDirection = 3'd2;
      step(1'b1, 1'b0, 1'b0, 4'b0);
      frames(6, 1'b0);
      check("edge_6f_active", int'(shotActive), 1);
      check("edge_6f_x", sx(0), 639);
      frames(1, 1'b0);
      check("edge_7f_active", int'(shotActive), 0);
      check("edge_7f_x", sx(0), 781);

      // Pause freezes motion and cooldown; collision still retires.
      do_reset();
      player_topLeftX = 11'sd320; player_topLeftY = 11'sd400; shotDirection = 3'd0;
      step(1'b1, 1'b0, 1'b0, 4'b0);
      frames(1, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b1, 4'b0);
      check("pause_y", sy(0), 398);
      check("pause_canfire", int'(canFire), 0);
      frames(6, 1'b0);
      check("pause_cool_6", int'(canFire), 0);
      frames(1, 1'b0);
      check("pause_cool_7", int'(canFire), 1);
      check("pause_y_8f", sy(0), 387);
      step(1'b0, 1'b0, 1'b1, 4'b0001);
      check("pause_collision", int'(shotActive), 0);

      // Diagonal launch, then asynchronous reset mid-flight.
      do_reset();
      player_topLeftX = 11'sd100; player_topLeftY = 11'sd300; shotDirection = 3'd1;
      step(1'b1, 1'b0, 1'b0, 4'b0);
      frames(1, 1'b0);
`ifdef SHOT_DIAGONAL_EN
      check("diag_x", sx(0), 101);
`else
      check("diag_x", sx(0), 100);
`endif
      check("diag_y", sy(0), 298);
      #2 resetN = 1'b0;
      #1;
      check("async_rst_active", int'(shotActive), 0);
      check("async_rst_x", sx(0), 781);
      check("async_rst_canfire", int'(canFire), 1);
      @(negedge clk);
      resetN = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
